dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequences every access to the word-wide data memory and shares that memory between two requesters: the pipeline load/store path (P) and a debug/loader port (D). Sub-word stores (SB/SH) become read-modify-write sequences. Loads return formatted data for LB/LH/LW/LBU/LHU. A fixed-priority arbiter favours P, and a starvation counter guarantees that D is eventually served.

Parameters:
DM_ADDRESS, 9, byte-address width; memory word index is DM_ADDRESS-2 bits
DATA_W, 32, data width (only 32 supported)
STARVE_MAX, 4, consecutive P grants allowed while D is waiting, before D is forced

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
p_req  in  1  P request; held until p_done
p_we  in  1  P store(1) / load(0)
p_addr  in  DM_ADDRESS  P byte address
p_wdata  in  DATA_W  P store data (SB: [7:0], SH: [15:0])
p_funct3  in  3  P size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
p_done  out  1  one-cycle completion pulse to P
p_err  out  1  misalignment flag, valid with p_done
p_rdata  out  DATA_W  P load result, valid with p_done
d_req  in  1  D request; held until d_done
d_we  in  1  D store / load; always word access
d_addr  in  DM_ADDRESS  D byte address
d_wdata  in  DATA_W  D store data
d_done  out  1  one-cycle completion pulse to D
d_err  out  1  misalignment flag, valid with d_done
d_rdata  out  DATA_W  D load result (raw word)
m_addr  out  DM_ADDRESS-2  memory word address
m_wd  out  DATA_W  memory write data
m_we  out  1  memory write enable; memory writes on the rising edge while high
m_rd  in  DATA_W  memory read data; valid the cycle after m_addr is presented with m_we=0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): FSM returns to IDLE. All outputs are 0: p_done, p_err, p_rdata, d_done, d_err, d_rdata, m_addr, m_wd, m_we and busy. starve_cnt is cleared. An in-flight operation is aborted; m_we drops during reset, so no partial write is committed.
- States:
  - IDLE: arbitrate.
  - RD: present m_addr for the read.
  - CAP: capture m_rd.
  - WR: m_we=1.
- Arbitration in IDLE, at a rising edge:
  - No grant is issued at an edge where p_done or d_done is high. Requesters drop or replace req during their done cycle.
  - Only one requester pending: grant it.
  - Both pending: grant P, unless starve_cnt==STARVE_MAX, in which case grant D.
  - Counter update: a P grant with d_req high increments starve_cnt. A D grant, or an arbitration edge with d_req low, clears starve_cnt.
  - At grant, latch the request fields into internal registers; later changes to req or data are ignored.
- Alignment check at grant:
  - H accesses require addr[0]=0.
  - W accesses (P funct3 010 or other codes, and all D accesses) require addr[1:0]=00.
  - Misaligned: no memory access. At the next edge, done=1, err=1 and rdata=0; FSM stays IDLE.
- Word store:
  - IDLE -> WR; m_addr = addr[DM_ADDRESS-1:2], m_wd = wdata.
  - At the edge ending WR, the memory writes, done=1, and the FSM returns to IDLE.
  - Latency: done is high 1 cycle after the accepting edge.
- Load:
  - IDLE -> RD -> CAP -> IDLE.
  - At the edge ending CAP, rdata gets the formatted m_rd and done=1.
  - Latency: done is high 2 cycles after acceptance.
  - Lane = addr[1:0] for B, addr[1] for H.
  - LB/LH: sign-extend the selected lane, right-aligned.
  - LBU/LHU: zero-extend the selected lane.
  - LW, and undefined funct3 codes: raw word.
  - D loads: raw word.
- Sub-word store (SB/SH):
  - IDLE -> RD -> CAP -> WR.
  - In CAP, merge wdata[7:0] or wdata[15:0] into the captured word at the lane; all other bytes are preserved.
  - WR writes the merged word; done is high 3 cycles after acceptance.
- m_addr and m_wd hold their last values in IDLE; m_we=1 only in WR.
- done and err pulses last exactly one cycle; rdata holds until the next completion to the same requester.

Test Plan:
- Reset, then P SW addr=0x010, wdata=0xDEADBEEF -> m_we=1 for one cycle with m_addr=0x04; p_done 1 cycle after accept; a following P LW 0x010 returns p_rdata=0xDEADBEEF with done 2 cycles after accept.
- Memory word 0x04 = 0x11223344, P SB addr=0x012, wdata=0xAA -> RD, CAP, WR sequence; memory becomes 0x11AA3344; p_done 3 cycles after accept.
- Memory word = 0x80F07F01: LB at 0x013 -> 0xFFFFFF80; LBU at 0x013 -> 0x00000080; LH at 0x012 -> 0xFFFF80F0; LHU at 0x010 -> 0x00007F01.
- P LH addr=0x011 -> no m_we, no RD state; p_done=1 and p_err=1 with p_rdata=0 one cycle after accept. D LW addr=0x002 -> d_err=1.
- p_req and d_req held continuously, P re-requesting after each done, STARVE_MAX=4 -> grant order P,P,P,P,D,P...; d_done occurs within 5 P operations.
- rst_n driven low during the CAP cycle of an SB -> m_we stays 0, busy=0 and all done signals 0 immediately; memory is unchanged; after release, a new P request is served normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer shared by the pipeline (P) and debug (D) ports.
// Sub-word stores run as read-modify-write; loads are formatted per funct3.
module dmem_access_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p_req,
  input  logic                  p_we,
  input  logic [DM_ADDRESS-1:0] p_addr,
  input  logic [DATA_W-1:0]     p_wdata,
  input  logic [2:0]            p_funct3,
  output logic                  p_done,
  output logic                  p_err,
  output logic [DATA_W-1:0]     p_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DM_ADDRESS-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic [DATA_W-1:0]     d_rdata,
  output logic [DM_ADDRESS-3:0] m_addr,
  output logic [DATA_W-1:0]     m_wd,
  output logic                  m_we,
  input  logic [DATA_W-1:0]     m_rd,
  output logic                  busy
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t              state, state_nx;
  logic [CW-1:0]       starve_cnt;
  logic                r_d, r_we, err_pend;
  size_t               r_size;
  logic [2:0]          r_f3;
  logic [1:0]          r_lane;
  logic [DATA_W-1:0]   r_wdata;

  // Stores only go sub-word for SB/SH; loads also treat BU/HU as narrow.
  function automatic size_t size_of(input logic we, input logic [2:0] f3);
    if (f3 == 3'b000 || (!we && f3 == 3'b100)) return SZ_B;
    if (f3 == 3'b001 || (!we && f3 == 3'b101)) return SZ_H;
    return SZ_W;
  endfunction

  logic                  arb, gnt_p, gnt_d, gnt, g_we, g_mis;
  size_t                 g_size;
  logic [DM_ADDRESS-1:0] g_addr;
  logic [DATA_W-1:0]     g_wdata;

  // A pending misalign report blocks arbitration just like a done pulse.
  assign arb     = (state == IDLE) && !p_done && !d_done && !err_pend;
  assign gnt_d   = arb && d_req && (!p_req || starve_cnt == CW'(STARVE_MAX));
  assign gnt_p   = arb && p_req && !gnt_d;
  assign gnt     = gnt_p || gnt_d;
  assign g_we    = gnt_d ? d_we : p_we;
  assign g_addr  = gnt_d ? d_addr : p_addr;
  assign g_wdata = gnt_d ? d_wdata : p_wdata;
  assign g_size  = gnt_d ? SZ_W : size_of(p_we, p_funct3);
  assign g_mis   = (g_size == SZ_H && g_addr[0]) ||
                   (g_size == SZ_W && g_addr[1:0] != 2'b00);

  logic [4:0]        sh;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] msk, merged, ld_val, fin_val;
  logic              fin, fin_rd;

  always_comb begin
    sh     = (r_size == SZ_B) ? {r_lane, 3'b000} : {r_lane[1], 4'b0000};
    lane_b = 8'(m_rd >> sh);
    lane_h = 16'(m_rd >> sh);
    msk    = ((r_size == SZ_B) ? DATA_W'(8'hFF) : DATA_W'(16'hFFFF)) << sh;
    merged = (m_rd & ~msk) | ((r_wdata << sh) & msk);
    case (r_f3)
      3'b000:  ld_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_val = {24'b0, lane_b};
      3'b101:  ld_val = {16'b0, lane_h};
      default: ld_val = m_rd;
    endcase
    fin     = err_pend || (state == CAP && !r_we) || (state == WR);
    fin_rd  = err_pend || (state == CAP && !r_we);
    fin_val = err_pend ? '0 : ld_val;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt && !g_mis) state_nx = (g_we && g_size == SZ_W) ? WR : RD;
      RD:      state_nx = CAP;
      CAP:     state_nx = r_we ? WR : IDLE;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign m_we = (state == WR);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      r_d        <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= SZ_W;
      r_f3       <= 3'b010;
      r_lane     <= 2'b00;
      r_wdata    <= '0;
      err_pend   <= 1'b0;
      p_done     <= 1'b0;
      p_err      <= 1'b0;
      p_rdata    <= '0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      m_addr     <= '0;
      m_wd       <= '0;
    end else begin
      state    <= state_nx;
      err_pend <= gnt && g_mis;
      p_done   <= fin && !r_d;
      d_done   <= fin && r_d;
      p_err    <= err_pend && !r_d;
      d_err    <= err_pend && r_d;
      if (fin_rd && !r_d) p_rdata <= fin_val;
      if (fin_rd && r_d)  d_rdata <= fin_val;
      if (arb) starve_cnt <= (gnt_p && d_req) ? starve_cnt + CW'(1) : '0;
      if (gnt) begin
        r_d     <= gnt_d;
        r_we    <= g_we;
        r_size  <= g_size;
        r_f3    <= gnt_d ? 3'b010 : p_funct3;
        r_lane  <= g_addr[1:0];
        r_wdata <= g_wdata;
        if (!g_mis) m_addr <= g_addr[DM_ADDRESS-1:2];
        if (!g_mis && g_we && g_size == SZ_W) m_wd <= g_wdata;
      end
      if (state == CAP && r_we) m_wd <= merged;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed + randomized bench for dmem_access_ctrl against a word-array model.
module tb_dmem_access_ctrl;
  localparam int DMA = 9;
  localparam int SM  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           p_req, p_we, d_req, d_we;
  logic [DMA-1:0] p_addr, d_addr;
  logic [31:0]    p_wdata, d_wdata, p_rdata, d_rdata, m_wd, m_rd;
  logic [2:0]     p_funct3;
  logic           p_done, p_err, d_done, d_err, m_we, busy;
  logic [DMA-3:0] m_addr;

  logic [31:0] mem     [0:127];
  logic [31:0] ref_mem [0:127];
  logic        load_mem;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.DM_ADDRESS(DMA), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_funct3(p_funct3),
    .p_done(p_done), .p_err(p_err), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_rd(m_rd), .busy(busy)
  );

  // Synchronous-read word memory the controller drives.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= ref_mem[i];
    end else if (m_we) begin
      mem[m_addr] <= m_wd;
    end
    m_rd <= mem[m_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction from a single requester, started at a negedge.
  task automatic op(input bit is_d, input bit we, input logic [8:0] addr,
                    input logic [31:0] wd, input logic [2:0] f3);
    int sz, lat, n, wes, a, wi, bsh, hsh;
    logic mis, dn;
    logic [31:0] word, b, h, exp, waddr, wval, new_word;
    a = int'(addr); wi = a / 4;
    if (is_d) sz = 2;
    else if (we) sz = (f3 == 3'd0) ? 0 : (f3 == 3'd1) ? 1 : 2;
    else sz = (f3 == 3'd0 || f3 == 3'd4) ? 0 : (f3 == 3'd1 || f3 == 3'd5) ? 1 : 2;
    mis  = (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    word = ref_mem[wi];
    bsh  = 8 * (a % 4);
    hsh  = 16 * ((a / 2) % 2);
    b    = (word >> bsh) & 32'hFF;
    h    = (word >> hsh) & 32'hFFFF;
    exp  = 32'h0;
    new_word = word;
    if (mis) lat = 1;
    else if (we) begin
      lat = (sz == 2) ? 1 : 3;
      if (sz == 2) new_word = wd;
      else if (sz == 0) new_word = (word & ~(32'hFF << bsh)) | ((wd & 32'hFF) << bsh);
      else new_word = (word & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
      ref_mem[wi] = new_word;
    end else begin
      lat = 2;
      if (is_d) exp = word;
      else case (f3)
        3'd0:    exp = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        3'd1:    exp = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        3'd4:    exp = b;
        3'd5:    exp = h;
        default: exp = word;
      endcase
    end
    if (is_d) begin d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1; end
    else begin p_we = we; p_addr = addr; p_wdata = wd; p_funct3 = f3; p_req = 1'b1; end
    n = 0; wes = 0; waddr = 0; wval = 0;
    do begin
      @(negedge clk);
      n++;
      if (m_we) begin wes++; waddr = 32'(m_addr); wval = m_wd; end
      dn = is_d ? d_done : p_done;
    end while (!dn && n < 20);
    p_req = 1'b0; d_req = 1'b0;
    chk(is_d ? "d_latency" : "p_latency", 32'(n), 32'(lat + 1));
    chk(is_d ? "d_err" : "p_err", 32'(is_d ? d_err : p_err), 32'(mis));
    if (!we || mis) chk(is_d ? "d_rdata" : "p_rdata", is_d ? d_rdata : p_rdata, exp);
    chk("m_we_pulses", 32'(wes), 32'((we && !mis) ? 1 : 0));
    if (we && !mis) begin
      chk("m_addr_wr", waddr, 32'(wi));
      chk("m_wd_wr", wval, new_word);
    end
    @(negedge clk);
  endtask

  initial begin
    int pcount, pbefore, nbad;
    bit dseen;
    logic [2:0] f3s [0:6];
    f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4;
    f3s[4] = 3'd5; f3s[5] = 3'd3; f3s[6] = 3'd7;
    for (int i = 0; i < 128; i++) ref_mem[i] = $urandom;
    rst_n = 1'b0; load_mem = 1'b1;
    p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0; p_funct3 = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    load_mem = 1'b0;
    chk("rst_outputs", {p_done, p_err, d_done, d_err, m_we, busy}, 32'h0);
    chk("rst_p_rdata", p_rdata, 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    chk("rst_m_wd", m_wd, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    op(0, 1, 9'h010, 32'hDEADBEEF, 3'd2);
    op(0, 0, 9'h010, 32'h0, 3'd2);
    chk("lw_after_sw", p_rdata, 32'hDEADBEEF);
    op(1, 1, 9'h010, 32'h11223344, 3'd2);
    op(0, 1, 9'h012, 32'h000000AA, 3'd0);
    op(1, 0, 9'h010, 32'h0, 3'd2);
    chk("sb_merge", d_rdata, 32'h11AA3344);
    op(1, 1, 9'h010, 32'h80F07F01, 3'd2);
    op(0, 0, 9'h013, 32'h0, 3'd0);
    chk("lb_sext", p_rdata, 32'hFFFFFF80);
    op(0, 0, 9'h013, 32'h0, 3'd4);
    op(0, 0, 9'h012, 32'h0, 3'd1);
    chk("lh_sext", p_rdata, 32'hFFFF80F0);
    op(0, 0, 9'h010, 32'h0, 3'd5);
    op(0, 0, 9'h011, 32'h0, 3'd1);
    op(1, 0, 9'h002, 32'h0, 3'd2);
    op(0, 1, 9'h013, 32'h0000BEEF, 3'd1);

    // Both ports held; D must win once P has taken STARVE_MAX grants.
    p_we = 0; p_addr = 9'h010; p_funct3 = 3'd2; p_req = 1'b1;
    d_we = 0; d_addr = 9'h020; d_req = 1'b1;
    pcount = 0; pbefore = -1; dseen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (d_done) begin
        dseen = 1; pbefore = pcount; d_req = 1'b0;
        chk("starve_d_rdata", d_rdata, ref_mem[8]);
      end
      if (p_done) begin
        pcount++;
        chk("starve_p_rdata", p_rdata, ref_mem[4]);
        if (dseen) begin p_req = 1'b0; break; end
      end
    end
    p_req = 1'b0; d_req = 1'b0;
    chk("starve_order", 32'(pbefore), 32'(SM));
    chk("starve_p_after_d", 32'(pcount), 32'(SM + 1));
    @(negedge clk);

    // Reset in the middle of a sub-word store must abort without writing.
    op(1, 1, 9'h010, 32'h11223344, 3'd2);
    p_we = 1; p_addr = 9'h012; p_wdata = 32'h55; p_funct3 = 3'd0; p_req = 1'b1;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_m_we", 32'(m_we), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", {p_done, d_done}, 32'h0);
    p_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem", mem[4], 32'h11223344);
    op(0, 1, 9'h012, 32'h66, 3'd0);
    op(0, 0, 9'h010, 32'h0, 3'd2);
    chk("after_abort", p_rdata, 32'h11663344);

    for (int k = 0; k < 60; k++) begin
      bit isd, we;
      logic [8:0] ad;
      logic [2:0] f;
      isd = ($urandom_range(0, 3) == 0);
      we  = $urandom_range(0, 1) == 1;
      ad  = 9'($urandom);
      f   = we ? 3'($urandom_range(0, 2)) : f3s[$urandom_range(0, 6)];
      op(isd, we, ad, $urandom, f);
    end

    repeat (2) @(negedge clk);
    nbad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_final", 32'(nbad), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
